// File: rtl/enigma_pkg.sv
// enigma_pkg
// Shared definitions for the Enigma byte-stream front end: the controller
// FSM state encoding, the ASCII code points the controller classifies and
// emits, and small classification helpers for incoming bytes.
package enigma_pkg;

  // Controller states. GROUP_SPACE is only ever entered when the five-letter
  // grouping option (ENIGMA_GROUP5_EN) is compiled in.
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_CORE,
    SEND,
    TX_GUARD,
    TX_WAIT,
    GROUP_SPACE
  } state_t;

  localparam int LETTERS   = 26;
  localparam int GROUP_LEN = 5;

  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_Z  = ASCII_A  + 8'(LETTERS - 1);
  localparam logic [7:0] ASCII_LZ = ASCII_LA + 8'(LETTERS - 1);

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= ASCII_A) && (b <= ASCII_Z);
  endfunction

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= ASCII_LA) && (b <= ASCII_LZ);
  endfunction

endpackage

// File: rtl/enigma_byte_fifo.sv
// enigma_byte_fifo
// Small synchronous byte FIFO with a registered occupancy count. Fullness is
// judged on the registered count only, so a pop in the same cycle does not
// make room for a push into a full FIFO; that push is simply ignored.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data this cycle (ignored when full)
//   push_data   8-bit byte to store
//   pop         discard the head entry this cycle (ignored when empty)
//   head_data   current head entry (valid when !empty)
//   empty, full occupancy flags derived from the registered count
module enigma_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Next-state for storage, pointers and count. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  // Register update; storage contents need no reset since count gates them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/enigma_stream_ctrl.sv
// enigma_stream_ctrl
// Byte-stream front end for the Enigma core. Buffers received ASCII bytes,
// normalises letters to 0..25, issues them one at a time to the core, waits
// (with a timeout) for the result, and hands the uppercase result to the
// UART transmitter under a busy/start handshake.
//
// Build option: define ENIGMA_GROUP5_EN to insert a space after every fifth
// encrypted letter (counter cleared by rst and by passed-through CR/LF).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_valid, rx_data   received byte strobe and data
//   core_valid          one-cycle issue strobe to the core
//   core_char           letter index 0..25 for the core
//   core_result_valid   core result strobe
//   core_result         encrypted letter index
//   tx_busy             transmitter busy
//   tx_start, tx_data   one-cycle transmit start strobe and byte
//   overflow            sticky: a received byte was dropped (FIFO full)
//   core_err            sticky: a core response timed out
//   char_count          letters successfully encrypted (wraps)
module enigma_stream_ctrl
  import enigma_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter bit PASS_NONALPHA = 1'b1,
  parameter int TIMEOUT       = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        core_valid,
  output logic [4:0]  core_char,
  input  logic        core_result_valid,
  input  logic [4:0]  core_result,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        overflow,
  output logic        core_err,
  output logic [15:0] char_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [4:0]    index_q, index_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          overflow_q, overflow_d;
  logic          core_err_q, core_err_d;
  logic [15:0]   char_count_q, char_count_d;
`ifdef ENIGMA_GROUP5_EN
  logic [2:0]    group_q, group_d;
  logic          group_due_q, group_due_d;
`endif

  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       fifo_empty;
  logic       fifo_full;

  enigma_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_valid),
    .push_data(rx_data),
    .pop      (fifo_pop),
    .head_data(fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign core_char  = index_q;
  assign tx_data    = tx_byte_q;
  assign overflow   = overflow_q;
  assign core_err   = core_err_q;
  assign char_count = char_count_q;

  // Next-state and strobe logic. tx_byte only changes in IDLE, WAIT_CORE and
  // GROUP_SPACE, which keeps tx_data stable across SEND/TX_GUARD/TX_WAIT.
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    tx_byte_d    = tx_byte_q;
    timer_d      = timer_q;
    core_err_d   = core_err_q;
    char_count_d = char_count_q;
    overflow_d   = overflow_q | (rx_valid & fifo_full);
    fifo_pop     = 1'b0;
    core_valid   = (state_q == ISSUE);
    tx_start     = (state_q == SEND) && !tx_busy;
`ifdef ENIGMA_GROUP5_EN
    group_d      = group_q;
    group_due_d  = group_due_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_upper(fifo_head)) begin
            index_d = 5'(fifo_head - ASCII_A);
            state_d = ISSUE;
          end else if (is_lower(fifo_head)) begin
            index_d = 5'(fifo_head - ASCII_LA);
            state_d = ISSUE;
          end else if (PASS_NONALPHA) begin
            tx_byte_d = fifo_head;
            state_d   = SEND;
`ifdef ENIGMA_GROUP5_EN
            if (fifo_head == ASCII_CR || fifo_head == ASCII_LF) group_d = '0;
`endif
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_CORE;
      end
      WAIT_CORE: begin
        // A result arriving on the final allowed cycle still wins.
        if (core_result_valid) begin
          tx_byte_d    = {3'b000, core_result} + ASCII_A;
          char_count_d = char_count_q + 16'd1;
          state_d      = SEND;
`ifdef ENIGMA_GROUP5_EN
          if (group_q == 3'(GROUP_LEN - 1)) begin
            group_d     = '0;
            group_due_d = 1'b1;
          end else begin
            group_d = group_q + 3'd1;
          end
`endif
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          core_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SEND: begin
        if (!tx_busy) state_d = TX_GUARD;
      end
      TX_GUARD: begin
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (!tx_busy) begin
`ifdef ENIGMA_GROUP5_EN
          if (group_due_q) begin
            group_due_d = 1'b0;
            state_d     = GROUP_SPACE;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef ENIGMA_GROUP5_EN
      GROUP_SPACE: begin
        tx_byte_d = ASCII_SP;
        state_d   = SEND;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight character.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      index_q      <= '0;
      tx_byte_q    <= '0;
      timer_q      <= '0;
      overflow_q   <= 1'b0;
      core_err_q   <= 1'b0;
      char_count_q <= '0;
`ifdef ENIGMA_GROUP5_EN
      group_q      <= '0;
      group_due_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      tx_byte_q    <= tx_byte_d;
      timer_q      <= timer_d;
      overflow_q   <= overflow_d;
      core_err_q   <= core_err_d;
      char_count_q <= char_count_d;
`ifdef ENIGMA_GROUP5_EN
      group_q      <= group_d;
      group_due_q  <= group_due_d;
`endif
    end
  end

endmodule

// File: tb/tb_enigma_stream_ctrl.sv
// tb_enigma_stream_ctrl
// Directed bench for enigma_stream_ctrl. A stub core returns (index+1) mod 26
// one cycle after core_valid (optionally suppressed), and a TX model holds
// busy for 10 cycles after each start and logs every transmitted byte.
// A second instance with PASS_NONALPHA=0 checks that non-letters are dropped.
module tb_enigma_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        core_valid;
  logic [4:0]  core_char;
  logic        core_result_valid = 1'b0;
  logic [4:0]  core_result = '0;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        overflow;
  logic        core_err;
  logic [15:0] char_count;

  logic        rx_valid_b;
  logic [7:0]  rx_data_b;
  logic        core_valid_b;
  logic [4:0]  core_char_b;
  logic        core_result_valid_b = 1'b0;
  logic [4:0]  core_result_b = '0;
  logic        tx_start_b;
  logic [7:0]  tx_data_b;
  logic        overflow_b;
  logic        core_err_b;
  logic [15:0] char_count_b;

  logic        suppress;
  logic        force_busy;
  int          busy_cnt = 0;
  int          core_valid_cnt = 0;
  int          drop_tx_cnt = 0;
  int          drop_cv_cnt = 0;
  logic [7:0]  drop_tx_last = '0;
  logic [7:0]  tx_log [$];
  logic [7:0]  exp_q [$];

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  always #5 clk = ~clk;

  enigma_stream_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .core_valid       (core_valid),
    .core_char        (core_char),
    .core_result_valid(core_result_valid),
    .core_result      (core_result),
    .tx_busy          (tx_busy),
    .tx_start         (tx_start),
    .tx_data          (tx_data),
    .overflow         (overflow),
    .core_err         (core_err),
    .char_count       (char_count)
  );

  enigma_stream_ctrl #(.PASS_NONALPHA(1'b0)) dut_drop (
    .clk              (clk),
    .rst              (rst),
    .rx_valid         (rx_valid_b),
    .rx_data          (rx_data_b),
    .core_valid       (core_valid_b),
    .core_char        (core_char_b),
    .core_result_valid(core_result_valid_b),
    .core_result      (core_result_b),
    .tx_busy          (1'b0),
    .tx_start         (tx_start_b),
    .tx_data          (tx_data_b),
    .overflow         (overflow_b),
    .core_err         (core_err_b),
    .char_count       (char_count_b)
  );

  assign tx_busy = force_busy || (busy_cnt != 0);

  // Stub cores: answer (index+1) mod 26 one cycle after the issue strobe.
  always @(posedge clk) begin
    core_result_valid   <= core_valid && !suppress;
    core_result         <= (core_char == 5'd25) ? 5'd0 : core_char + 5'd1;
    core_result_valid_b <= core_valid_b;
    core_result_b       <= (core_char_b == 5'd25) ? 5'd0 : core_char_b + 5'd1;
  end

  // TX model and activity monitors for both instances.
  always @(posedge clk) begin
    if (tx_start) begin
      busy_cnt <= 10;
      tx_log.push_back(tx_data);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (core_valid)   core_valid_cnt <= core_valid_cnt + 1;
    if (core_valid_b) drop_cv_cnt    <= drop_cv_cnt + 1;
    if (tx_start_b) begin
      drop_tx_cnt  <= drop_tx_cnt + 1;
      drop_tx_last <= tx_data_b;
    end
  end

  // Drive one byte for one cycle; called and returns at a falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int base;
    int cv0;
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = '0;
    rx_valid_b = 1'b0;
    rx_data_b  = '0;
    suppress   = 1'b0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_core_valid", core_valid, 0);
    checkOutput("rst_tx_start", tx_start, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_core_err", core_err, 0);
    checkOutput("rst_char_count", char_count, 0);
    rst = 1'b0;

    $display("[TB] uppercase A");
    applyStimulus(8'h41);
    @(negedge clk);
    checkOutput("A_core_valid", core_valid, 1);
    checkOutput("A_core_char", core_char, 0);
    @(negedge clk);
    checkOutput("A_core_valid_one_cycle", core_valid, 0);
    @(negedge clk);
    checkOutput("A_tx_start", tx_start, 1);
    checkOutput("A_tx_data", tx_data, 8'h42);
    checkOutput("A_char_count", char_count, 1);
    repeat (20) @(negedge clk);

    $display("[TB] lowercase z");
    applyStimulus(8'h7A);
    @(negedge clk);
    checkOutput("z_core_valid", core_valid, 1);
    checkOutput("z_core_char", core_char, 25);
    repeat (2) @(negedge clk);
    checkOutput("z_tx_start", tx_start, 1);
    checkOutput("z_tx_data", tx_data, 8'h41);
    checkOutput("z_char_count", char_count, 2);
    repeat (20) @(negedge clk);

    $display("[TB] passthrough !");
    cv0 = core_valid_cnt;
    applyStimulus(8'h21);
    @(negedge clk);
    checkOutput("bang_tx_start", tx_start, 1);
    checkOutput("bang_tx_data", tx_data, 8'h21);
    repeat (20) @(negedge clk);
    checkOutput("bang_no_core_valid", core_valid_cnt, cv0);
    checkOutput("bang_char_count", char_count, 2);

    $display("[TB] non-letter dropped when passthrough disabled");
    rx_valid_b = 1'b1;
    rx_data_b  = 8'h21;
    @(negedge clk);
    rx_valid_b = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("drop_no_tx", drop_tx_cnt, 0);
    checkOutput("drop_no_core", drop_cv_cnt, 0);
    rx_valid_b = 1'b1;
    rx_data_b  = 8'h62;
    @(negedge clk);
    rx_valid_b = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("drop_b_tx_cnt", drop_tx_cnt, 1);
    checkOutput("drop_b_tx_data", drop_tx_last, 8'h43);

    $display("[TB] overflow with transmitter held busy");
    base = tx_log.size();
    force_busy = 1'b1;
    applyStimulus(8'h23);
    repeat (3) @(negedge clk);
    checkOutput("ovf_before", overflow, 0);
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h41 + 8'(i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    checkOutput("ovf_set", overflow, 1);
    force_busy = 1'b0;
    for (int n = 0; n < 400 && tx_log.size() < base + 9; n++) @(negedge clk);
    repeat (30) @(negedge clk);
    checkOutput("ovf_tx_count", tx_log.size(), base + 9);
    if (tx_log.size() >= base + 9) begin
      checkOutput("ovf_tx_hash", tx_log[base], 8'h23);
      for (int i = 1; i <= 8; i++)
        checkOutput($sformatf("ovf_tx_%0d", i), tx_log[base+i], 8'h41 + 8'(i));
    end
    checkOutput("ovf_char_count", char_count, 10);
    repeat (20) @(negedge clk);

    $display("[TB] core timeout");
    base = tx_log.size();
    suppress = 1'b1;
    applyStimulus(8'h43);
    repeat (16) @(negedge clk);
    checkOutput("to_err_not_yet", core_err, 0);
    @(negedge clk);
    checkOutput("to_err_set", core_err, 1);
    suppress = 1'b0;
    applyStimulus(8'h44);
    @(negedge clk);
    checkOutput("to_next_core_valid", core_valid, 1);
    checkOutput("to_next_core_char", core_char, 3);
    repeat (2) @(negedge clk);
    checkOutput("to_next_tx_start", tx_start, 1);
    checkOutput("to_next_tx_data", tx_data, 8'h45);
    checkOutput("to_char_count", char_count, 11);
    checkOutput("to_no_tx_for_timeout", tx_log.size(), base);
    repeat (20) @(negedge clk);

    $display("[TB] reset during WAIT_CORE");
    suppress = 1'b1;
    applyStimulus(8'h43);
    applyStimulus(8'h44);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mrst_core_valid", core_valid, 0);
    checkOutput("mrst_core_char", core_char, 0);
    checkOutput("mrst_tx_start", tx_start, 0);
    checkOutput("mrst_tx_data", tx_data, 0);
    checkOutput("mrst_overflow", overflow, 0);
    checkOutput("mrst_core_err", core_err, 0);
    checkOutput("mrst_char_count", char_count, 0);
    rst = 1'b0;
    suppress = 1'b0;
    cv0 = core_valid_cnt;
    base = tx_log.size();
    repeat (20) @(negedge clk);
    checkOutput("mrst_fifo_empty", core_valid_cnt, cv0);
    checkOutput("mrst_no_tx", tx_log.size(), base);

    $display("[TB] ABCDEF sequence");
`ifdef ENIGMA_GROUP5_EN
    exp_q = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h20, 8'h47};
`else
    exp_q = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
`endif
    base = tx_log.size();
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h41 + 8'(i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    for (int n = 0; n < 600 && tx_log.size() < base + exp_q.size(); n++) @(negedge clk);
    repeat (30) @(negedge clk);
    checkOutput("grp_tx_count", tx_log.size(), base + exp_q.size());
    if (tx_log.size() >= base + exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++)
        checkOutput($sformatf("grp_tx_%0d", i), tx_log[base+i], exp_q[i]);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
